// File: rtl/rom_loader.sv
// rom_loader: byte-stream program loader for the instruction ROM.
//
// Each load is a 4-byte little-endian word-count header followed by the
// payload. Payload bytes are packed little-endian into 32-bit words, and the
// words are written to consecutive word addresses starting at BASE_ADDR.
// While a load is in progress, busy holds the CPU.
//
// Ports:
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   start     one-cycle pulse, begins a load when idle
//   abort     synchronous cancel, returns to idle from any state
//   rx_valid  byte source has a byte on rx_data
//   rx_data   byte from the source
//   rx_ready  loader accepts a byte (transfer on rx_valid && rx_ready)
//   wen       ROM write strobe, one cycle per word
//   w_addr    ROM byte address (word aligned), holds last written value
//   w_data    ROM write data, holds last written value
//   busy      load in progress / CPU hold
//   done      one-cycle pulse on successful completion
//   err       one-cycle pulse when the length header is rejected
module rom_loader #(
    parameter int              AW        = 32,
    parameter int              MEM_NUM   = 4096,
    parameter logic [AW-1:0]   BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          wen,
    output logic [AW-1:0] w_addr,
    output logic [31:0]   w_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] LEN_MAX = 32'(MEM_NUM);

    state_t        state;
    state_t        state_next;
    logic [1:0]    byte_cnt;
    logic [AW-1:0] word_cnt;
    logic [31:0]   len;
    logic [23:0]   asm_buf;

    logic          xfer;
    logic          byte_last;
    logic          word_last;
    logic [31:0]   full_word;

    assign xfer      = rx_valid && rx_ready;
    assign byte_last = (byte_cnt == 2'd3);
    // The word completed by the current 4th byte: lower three bytes are
    // already buffered, the top byte is on rx_data this cycle.
    assign full_word = {rx_data, asm_buf};
    assign word_last = (word_cnt == AW'(len - 32'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                rx_ready = 1'b1;
                if (xfer && byte_last) begin
                    if (full_word == 32'd0) begin
                        state_next = DONE;
                    end else if (full_word > LEN_MAX) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (xfer && byte_last && word_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                err        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            len      <= '0;
            asm_buf  <= '0;
            wen      <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
        end else if (abort) begin
            // Abort drops any partial word and a write that would have been
            // registered on this same edge.
            byte_cnt <= '0;
            word_cnt <= '0;
            wen      <= 1'b0;
        end else begin
            wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_cnt <= '0;
                        word_cnt <= '0;
                    end
                end
                HDR, DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_buf[7:0]   <= rx_data;
                            2'd1: asm_buf[15:8]  <= rx_data;
                            2'd2: asm_buf[23:16] <= rx_data;
                            default: begin
                                if (state == HDR) begin
                                    len <= full_word;
                                end else begin
                                    wen      <= 1'b1;
                                    w_addr   <= BASE_ADDR + {word_cnt[AW-3:0], 2'b00};
                                    w_data   <= full_word;
                                    word_cnt <= word_cnt + AW'(1);
                                end
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

    localparam int          AW      = 32;
    localparam int          MEM_NUM = 4096;
    localparam logic [31:0] BASE    = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          abort;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          wen;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_data;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    rom_loader #(
        .AW       (AW),
        .MEM_NUM  (MEM_NUM),
        .BASE_ADDR(BASE)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .abort   (abort),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ready(rx_ready),
        .wen     (wen),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          done_q[$];
    int          err_q[$];
    bit          busy_at[int];

    // expected result of a load, computed from the byte list
    logic [31:0] exp_d[$];
    int          exp_kind;   // 0 = done, 1 = err

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_at[cyc] = busy;
        if (wen === 1'b1) begin
            wa_q.push_back(w_addr);
            wd_q.push_back(w_data);
            wc_q.push_back(cyc);
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (err === 1'b1) err_q.push_back(cyc);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_q.delete();
        err_q.delete();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic model(input logic [7:0] b[$]);
        longint unsigned n;
        exp_d.delete();
        n = b[0] + 256 * b[1] + 65536 * b[2] + 16777216 * longint'(b[3]);
        if (n == 0) exp_kind = 0;
        else if (n > MEM_NUM) exp_kind = 1;
        else begin
            exp_kind = 0;
            for (int w = 0; w < int'(n); w++)
                exp_d.push_back(b[4+4*w] + 256 * b[5+4*w] + 65536 * b[6+4*w]
                                + 16777216 * longint'(b[7+4*w]));
        end
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int max_gap);
        bit sampled;
        int n;
        foreach (b[i]) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
            rx_valid = 1'b1;
            rx_data  = b[i];
            n = 0;
            do begin
                sampled = rx_ready;
                tick();
                n++;
            end while (!sampled && n < 50);
            total++;
            if (!sampled) begin
                bad++;
                $display("FAIL byte_accept idx=%0d: rx_ready never 1, required 1", i);
                rx_valid = 1'b0;
                return;
            end
            last_acc = cyc;
        end
        rx_valid = 1'b0;
    endtask

    task automatic settle;
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL settle: busy=%b, required 0", busy);
        end
        tick();
        tick();
    endtask

    task automatic run_load(input logic [7:0] b[$], input int max_gap);
        clear_log();
        model(b);
        pulse_start();
        send_bytes(b, max_gap);
        settle();
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b1; abort = 1'b0; rx_valid = 1'b1; rx_data = 8'hA5;
        repeat (3) tick();
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got %b, required 0", rx_ready); end
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b, required 0", wen); end
        total++; if (w_addr !== '0) begin bad++; $display("FAIL reset_w_addr: got %h, required 0", w_addr); end
        total++; if (w_data !== '0) begin bad++; $display("FAIL reset_w_data: got %h, required 0", w_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err: got %b%b, required 00", done, err); end
        start = 1'b0;
        rstn  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (rx_ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle: rx_ready=%b busy=%b, required 0 0", rx_ready, busy);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_normal;
        logic [7:0] b[$];
        b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_log();
        pulse_start();
        total++;
        if (busy !== 1'b1 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_latency: busy=%b rx_ready=%b, required 1 1", busy, rx_ready);
        end
        send_bytes(b, 0);
        settle();
        total++;
        if (wa_q.size() != 2 || done_q.size() != 1) begin
            bad++;
            $display("FAIL normal_counts: writes=%0d dones=%0d, required 2 1", wa_q.size(), done_q.size());
        end else begin
            total++; if (wa_q[0] !== BASE || wd_q[0] !== 32'h0000_0013) begin bad++;
                $display("FAIL normal_w0: %h/%h, required %h/00000013", wa_q[0], wd_q[0], BASE); end
            total++; if (wa_q[1] !== BASE + 32'd4 || wd_q[1] !== 32'hDEAD_BEEF) begin bad++;
                $display("FAIL normal_w1: %h/%h, required %h/deadbeef", wa_q[1], wd_q[1], BASE + 32'd4); end
            total++; if (wc_q[1] - wc_q[0] != 4) begin bad++;
                $display("FAIL normal_spacing: %0d cycles, required 4", wc_q[1] - wc_q[0]); end
            total++; if (wc_q[0] != last_acc - 4) begin bad++;
                $display("FAIL normal_wen_latency: cycle %0d, required %0d", wc_q[0], last_acc - 4); end
            total++; if (done_q[0] != wc_q[1]) begin bad++;
                $display("FAIL normal_done_align: done %0d, required %0d", done_q[0], wc_q[1]); end
            total++; if (busy_at[done_q[0] + 1] !== 1'b0) begin bad++;
                $display("FAIL normal_busy_drop: busy=%b, required 0", busy_at[done_q[0] + 1]); end
        end
    endtask

    task automatic test_empty_oversize;
        logic [7:0] b[$];
        b = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_load(b, 0);
        total++;
        if (wa_q.size() != 0 || done_q.size() != 1 || err_q.size() != 0) begin
            bad++;
            $display("FAIL empty_hdr: writes=%0d dones=%0d errs=%0d, required 0 1 0", wa_q.size(), done_q.size(), err_q.size());
        end
        b = '{8'h01, 8'h10, 8'h00, 8'h00};
        run_load(b, 0);
        total++;
        if (wa_q.size() != 0 || done_q.size() != 0 || err_q.size() != 1) begin
            bad++;
            $display("FAIL oversize_hdr: writes=%0d dones=%0d errs=%0d, required 0 0 1", wa_q.size(), done_q.size(), err_q.size());
        end else begin
            total++; if (err_q[0] != last_acc) begin bad++;
                $display("FAIL err_latency: cycle %0d, required %0d", err_q[0], last_acc); end
            total++; if (busy_at[err_q[0] + 1] !== 1'b0) begin bad++;
                $display("FAIL err_busy_drop: busy=%b, required 0", busy_at[err_q[0] + 1]); end
        end
        // largest legal header minus nothing: 4096 exactly is accepted (checked in boundary)
    endtask

    task automatic test_stall_random;
        logic [7:0] b[$];
        int n;
        for (int it = 0; it < 5; it++) begin
            b.delete();
            if (it == 0) begin
                b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                      8'hEF, 8'hBE, 8'hAD, 8'hDE};
            end else begin
                n = $urandom_range(6, 1);
                b = '{8'(n), 8'h00, 8'h00, 8'h00};
                for (int k = 0; k < 4 * n; k++) b.push_back(8'($urandom));
            end
            run_load(b, 5);
            total++;
            if (wa_q.size() != exp_d.size() || done_q.size() != 1) begin
                bad++;
                $display("FAIL stall_counts it=%0d: writes=%0d dones=%0d, required %0d 1", it, wa_q.size(), done_q.size(), exp_d.size());
            end else begin
                foreach (exp_d[w]) begin
                    total++;
                    if (wa_q[w] !== BASE + 32'(4 * w) || wd_q[w] !== exp_d[w]) begin
                        bad++;
                        $display("FAIL stall_write it=%0d w=%0d: %h/%h, required %h/%h", it, w, wa_q[w], wd_q[w], BASE + 32'(4 * w), exp_d[w]);
                    end
                end
                total++; if (done_q[0] != wc_q[wc_q.size() - 1]) begin bad++;
                    $display("FAIL stall_done_align it=%0d: done %0d, required %0d", it, done_q[0], wc_q[wc_q.size() - 1]); end
            end
        end
    endtask

    task automatic test_abort;
        logic [7:0] b[$];
        // abort after two payload bytes
        clear_log();
        pulse_start();
        b = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        send_bytes(b, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (busy !== 1'b0 || rx_ready !== 1'b0) begin bad++;
            $display("FAIL abort_idle: busy=%b rx_ready=%b, required 0 0", busy, rx_ready); end
        repeat (4) tick();
        total++; if (wa_q.size() != 0 || done_q.size() != 0) begin bad++;
            $display("FAIL abort_quiet: writes=%0d dones=%0d, required 0 0", wa_q.size(), done_q.size()); end

        // abort on the same edge as a word's 4th byte suppresses the write
        clear_log();
        pulse_start();
        b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        send_bytes(b, 0);
        rx_valid = 1'b1; rx_data = 8'h04; abort = 1'b1;
        tick();
        rx_valid = 1'b0; abort = 1'b0;
        repeat (4) tick();
        total++; if (wa_q.size() != 0 || done_q.size() != 0) begin bad++;
            $display("FAIL abort_same_edge: writes=%0d dones=%0d, required 0 0", wa_q.size(), done_q.size()); end

        // fresh load, with a start pulse in the middle of the payload
        clear_log();
        pulse_start();
        b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        send_bytes(b, 0);
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++;
            $display("FAIL start_in_data: busy=%b, required 1", busy); end
        b = '{8'hCC, 8'hDD};
        send_bytes(b, 0);
        settle();
        total++;
        if (wa_q.size() != 1 || done_q.size() != 1) begin
            bad++;
            $display("FAIL reload_counts: writes=%0d dones=%0d, required 1 1", wa_q.size(), done_q.size());
        end else begin
            total++; if (wa_q[0] !== BASE || wd_q[0] !== 32'hDDCC_BBAA) begin bad++;
                $display("FAIL reload_w0: %h/%h, required %h/ddccbbaa", wa_q[0], wd_q[0], BASE); end
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] b[$];
        clear_log();
        pulse_start();
        b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        send_bytes(b, 0);
        rx_valid = 1'b1; rx_data = 8'h60;
        #2 rstn = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || rx_ready !== 1'b0 || wen !== 1'b0 || w_addr !== '0 || w_data !== '0) begin
            bad++;
            $display("FAIL async_reset: busy=%b rx_ready=%b wen=%b addr=%h data=%h, required all 0", busy, rx_ready, wen, w_addr, w_data);
        end
        repeat (2) tick();
        rstn = 1'b1;
        rx_valid = 1'b0;
        repeat (4) tick();
        total++; if (wa_q.size() != 1 || done_q.size() != 0) begin bad++;
            $display("FAIL async_reset_writes: writes=%0d dones=%0d, required 1 0", wa_q.size(), done_q.size()); end
    endtask

    task automatic test_boundary;
        logic [7:0] b[$];
        int last;
        b = '{8'(MEM_NUM), 8'(MEM_NUM >> 8), 8'(MEM_NUM >> 16), 8'(MEM_NUM >> 24)};
        for (int k = 0; k < 4 * MEM_NUM; k++) b.push_back(8'($urandom));
        run_load(b, 0);
        total++;
        if (wa_q.size() != MEM_NUM || done_q.size() != 1) begin
            bad++;
            $display("FAIL boundary_counts: writes=%0d dones=%0d, required %0d 1", wa_q.size(), done_q.size(), MEM_NUM);
        end else begin
            last = MEM_NUM - 1;
            total++; if (wa_q[last] !== BASE + 32'(4 * last)) begin bad++;
                $display("FAIL boundary_last_addr: %h, required %h", wa_q[last], BASE + 32'(4 * last)); end
            total++; if (done_q[0] != wc_q[last]) begin bad++;
                $display("FAIL boundary_done_align: done %0d, required %0d", done_q[0], wc_q[last]); end
            begin
                int errs = 0;
                foreach (exp_d[w]) if (wd_q[w] !== exp_d[w] || wa_q[w] !== BASE + 32'(4 * w)) errs++;
                total++; if (errs != 0) begin bad++;
                    $display("FAIL boundary_data: %0d words wrong, required 0", errs); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_empty_oversize();
        test_stall_random();
        test_abort();
        test_async_reset();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
